mux_func_sweeper: RTL and testbench

- Parametrised successor to the fixed 4-variable, 8:1-mux function exercise.
- Implements an N-variable Boolean function with a 2^NSEL:1 mux. Per-input residue codes are configurable; the residue variable is the vector LSB.
- Self-sweeps all 2^(NSEL+1) input vectors, holding each for DWELL cycles, and compares the mux output against a loaded expected truth table.
- Reports the mismatch count and done status. Used as an on-chip self-checking replacement for the per-chapter stimulus benches.

---
 rtl/mux_func_sweeper_if.sv | 42 ++++
 rtl/mux_func_sweeper.sv | 177 +++++++++++++++++
 tb/tb_mux_func_sweeper.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mux_func_sweeper_if.sv
// mux_func_sweeper_if: groups the sweeper's control, configuration and status signals.
// Parameters: NSEL (mux select width), CW (error counter width).
// Signals: start_i, cfg_i, exp_i (driven by master); vec_o, y_o, mis_o,
//          err_cnt_o, busy_o, done_o (driven by slave).
// Optional macro MUXSWEEP_STOP_ON_FAIL_EN adds fail_vec_o.
interface mux_func_sweeper_if #(
  parameter int unsigned NSEL = 3,
  parameter int unsigned CW   = 8
) ();
  localparam int unsigned NV   = NSEL + 1;
  localparam int unsigned NIN  = 1 << NSEL;
  localparam int unsigned NVEC = 1 << NV;

  logic                start_i;
  logic [2*NIN-1:0]    cfg_i;
  logic [NVEC-1:0]     exp_i;
  logic [NV-1:0]       vec_o;
  logic                y_o;
  logic                mis_o;
  logic [CW-1:0]       err_cnt_o;
  logic                busy_o;
  logic                done_o;
`ifdef MUXSWEEP_STOP_ON_FAIL_EN
  logic [NV-1:0]       fail_vec_o;
`endif

  modport master (
    output start_i, cfg_i, exp_i,
    input  vec_o, y_o, mis_o, err_cnt_o, busy_o, done_o
`ifdef MUXSWEEP_STOP_ON_FAIL_EN
    , input fail_vec_o
`endif
  );

  modport slave (
    input  start_i, cfg_i, exp_i,
    output vec_o, y_o, mis_o, err_cnt_o, busy_o, done_o
`ifdef MUXSWEEP_STOP_ON_FAIL_EN
    , output fail_vec_o
`endif
  );
endinterface

// File: rtl/mux_func_sweeper.sv
// mux_func_sweeper: evaluates an NV-variable Boolean function built from a
// 2^NSEL:1 mux with per-input residue codes, sweeps every input vector
// (each held DWELL cycles) and counts mismatches against an expected truth table.
// Ports: clk, rst (synchronous, active-high), bus (mux_func_sweeper_if.slave):
//   start_i, cfg_i, exp_i in; vec_o, y_o (combinational), mis_o, err_cnt_o,
//   busy_o, done_o out.
// Optional macro MUXSWEEP_STOP_ON_FAIL_EN: adds fail_vec_o and ends the sweep
// on the first mismatch.
module mux_func_sweeper #(
  parameter int unsigned NSEL  = 3,
  parameter int unsigned DWELL = 1,
  parameter int unsigned CW    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  mux_func_sweeper_if.slave     bus
);
  localparam int unsigned NV   = NSEL + 1;
  localparam int unsigned NIN  = 1 << NSEL;
  localparam int unsigned NVEC = 1 << NV;
  localparam int unsigned CFGW = 2 * NIN;
  localparam int unsigned DCW  = 8;

  localparam logic [NV-1:0]  VEC_LAST = NV'(NVEC - 1);
  localparam logic [DCW-1:0] DW_LAST  = DCW'(DWELL - 1);
  localparam logic [CW-1:0]  ERR_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NV-1:0]     vec_q, vec_d;
  logic [DCW-1:0]    dwell_q, dwell_d;
  logic              mis_q, mis_d;
  logic [CW-1:0]     err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CFGW-1:0]   cfg_q, cfg_d;
  logic [NVEC-1:0]   exp_q, exp_d;
`ifdef MUXSWEEP_STOP_ON_FAIL_EN
  logic [NV-1:0]     fail_vec_q, fail_vec_d;
`endif

  // Mux datapath: upper vector bits select a residue code, vec[0] is D
  logic [NSEL-1:0]   sel_c;
  logic [1:0]        code_c;
  logic              y_c;
  logic              mis_c;
  logic              last_dwell_c;
  logic              abort_c;

  assign sel_c        = vec_q[NV-1:1];
  assign code_c       = cfg_q[{sel_c, 1'b0} +: 2];
  assign mis_c        = y_c ^ exp_q[vec_q];
  assign last_dwell_c = (dwell_q == DW_LAST);

  always_comb begin
    y_c = 1'b0;
    unique case (code_c)
      2'b00:   y_c = 1'b0;
      2'b01:   y_c = 1'b1;
      2'b10:   y_c = vec_q[0];
      2'b11:   y_c = ~vec_q[0];
      default: y_c = 1'b0;
    endcase
  end

  // A mismatch only terminates the sweep early when stop-on-fail is built in
`ifdef MUXSWEEP_STOP_ON_FAIL_EN
  assign abort_c = mis_c;
`else
  assign abort_c = 1'b0;
`endif

  // State register plus datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      vec_q      <= '0;
      dwell_q    <= '0;
      mis_q      <= 1'b0;
      err_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_q      <= '0;
      exp_q      <= '0;
`ifdef MUXSWEEP_STOP_ON_FAIL_EN
      fail_vec_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      dwell_q    <= dwell_d;
      mis_q      <= mis_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cfg_q      <= cfg_d;
      exp_q      <= exp_d;
`ifdef MUXSWEEP_STOP_ON_FAIL_EN
      fail_vec_q <= fail_vec_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start_i) state_d = S_SWEEP;
      end
      S_SWEEP: begin
        if (last_dwell_c && ((vec_q == VEC_LAST) || abort_c)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values; registers hold unless updated below
  always_comb begin
    vec_d   = vec_q;
    dwell_d = dwell_q;
    mis_d   = mis_q;
    err_d   = err_q;
    cfg_d   = cfg_q;
    exp_d   = exp_q;
    busy_d  = (state_d == S_SWEEP);
    done_d  = (state_d == S_DONE) && (state_q != S_DONE);
`ifdef MUXSWEEP_STOP_ON_FAIL_EN
    fail_vec_d = fail_vec_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start_i) begin
          cfg_d   = bus.cfg_i;
          exp_d   = bus.exp_i;
          vec_d   = '0;
          dwell_d = '0;
          mis_d   = 1'b0;
          err_d   = '0;
`ifdef MUXSWEEP_STOP_ON_FAIL_EN
          fail_vec_d = '0;
`endif
        end
      end
      S_SWEEP: begin
        if (last_dwell_c) begin
          dwell_d = '0;
          mis_d   = mis_c;
          if (mis_c && (err_q != ERR_MAX)) err_d = err_q + CW'(1);
`ifdef MUXSWEEP_STOP_ON_FAIL_EN
          if (mis_c && (err_q == '0)) fail_vec_d = vec_q;
`endif
          // Vector advances only while the sweep continues; it holds on exit
          if (state_d == S_SWEEP) vec_d = vec_q + NV'(1);
        end else begin
          dwell_d = dwell_q + DCW'(1);
        end
      end
      default: ;
    endcase
  end

  assign bus.vec_o     = vec_q;
  assign bus.y_o       = y_c;
  assign bus.mis_o     = mis_q;
  assign bus.err_cnt_o = err_q;
  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
`ifdef MUXSWEEP_STOP_ON_FAIL_EN
  assign bus.fail_vec_o = fail_vec_q;
`endif
endmodule

// File: tb/tb_mux_func_sweeper.sv
// tb_mux_func_sweeper: drives two sweeper instances (DWELL=1/CW=8 and
// DWELL=4/CW=3) and checks every sweep cycle against a truth-table model.
module tb_mux_func_sweeper;
`ifdef MUXSWEEP_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  logic [1:0]  st;
  logic [15:0] cfg_r [2];
  logic [15:0] exp_r [2];
  logic [3:0]  o_vec [2];
  logic        o_y   [2];
  logic        o_mis [2];
  logic [7:0]  o_err [2];
  logic        o_busy[2];
  logic        o_done[2];
  logic [3:0]  o_fv  [2];

  mux_func_sweeper_if #(.NSEL(3), .CW(8)) if0 ();
  mux_func_sweeper_if #(.NSEL(3), .CW(3)) if1 ();

  mux_func_sweeper #(.NSEL(3), .DWELL(1), .CW(8)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  mux_func_sweeper #(.NSEL(3), .DWELL(4), .CW(3)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  assign if0.start_i = st[0];
  assign if0.cfg_i   = cfg_r[0];
  assign if0.exp_i   = exp_r[0];
  assign if1.start_i = st[1];
  assign if1.cfg_i   = cfg_r[1];
  assign if1.exp_i   = exp_r[1];

  assign o_vec[0]  = if0.vec_o;
  assign o_y[0]    = if0.y_o;
  assign o_mis[0]  = if0.mis_o;
  assign o_err[0]  = if0.err_cnt_o;
  assign o_busy[0] = if0.busy_o;
  assign o_done[0] = if0.done_o;
  assign o_vec[1]  = if1.vec_o;
  assign o_y[1]    = if1.y_o;
  assign o_mis[1]  = if1.mis_o;
  assign o_err[1]  = 8'(if1.err_cnt_o);
  assign o_busy[1] = if1.busy_o;
  assign o_done[1] = if1.done_o;
`ifdef MUXSWEEP_STOP_ON_FAIL_EN
  assign o_fv[0] = if0.fail_vec_o;
  assign o_fv[1] = if1.fail_vec_o;
`else
  assign o_fv[0] = 4'd0;
  assign o_fv[1] = 4'd0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Function value straight from the residue-code rules
  function automatic bit model_y(input logic [15:0] cfg, input int v);
    int code;
    int d;
    code = int'((cfg >> (2 * (v / 2))) & 16'd3);
    d    = v % 2;
    case (code)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return bit'(d);
      default: return bit'(1 - d);
    endcase
  endfunction

  // One full sweep on instance s, checked every cycle until the cycle after done
  task automatic run_sweep(input int s, input logic [15:0] cfg, input logic [15:0] ex,
                           input bit disturb);
    bit yt[16];
    bit mm[16];
    int dwell, errmax, vend, cnt, ecnt, len, v;
    bit found;
    dwell  = (s == 0) ? 1 : 4;
    errmax = (s == 0) ? 255 : 7;
    vend   = 15;
    cnt    = 0;
    found  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      yt[i] = model_y(cfg, i);
      mm[i] = yt[i] ^ ex[i];
    end
    for (int i = 0; i < 16; i++) begin
      if (!(STOP && found)) begin
        if (mm[i]) cnt++;
        if (STOP && mm[i]) begin
          found = 1'b1;
          vend  = i;
        end
      end
    end
    ecnt = (cnt > errmax) ? errmax : cnt;
    len  = dwell * (vend + 1);

    @(negedge clk);
    cfg_r[s] = cfg;
    exp_r[s] = ex;
    st[s]    = 1'b1;
    @(negedge clk);
    st[s]    = 1'b0;
    for (int c = 1; c <= len; c++) begin
      v = (c - 1) / dwell;
      chk($sformatf("d%0d c%0d vec", s, c), 32'(o_vec[s]), 32'(v));
      chk($sformatf("d%0d c%0d y", s, c), 32'(o_y[s]), 32'(yt[v]));
      chk($sformatf("d%0d c%0d busy", s, c), 32'(o_busy[s]), 32'd1);
      chk($sformatf("d%0d c%0d done", s, c), 32'(o_done[s]), 32'd0);
      chk($sformatf("d%0d c%0d mis", s, c), 32'(o_mis[s]), (v == 0) ? 32'd0 : 32'(mm[v-1]));
      if (c == 1) chk($sformatf("d%0d err_clr", s), 32'(o_err[s]), 32'd0);
      if (disturb && c == 2 && len > 4) begin
        st[s]    = 1'b1;
        cfg_r[s] = 16'($urandom);
        exp_r[s] = 16'($urandom);
      end
      if (c == 3) st[s] = 1'b0;
      @(negedge clk);
    end
    chk($sformatf("d%0d end done", s), 32'(o_done[s]), 32'd1);
    chk($sformatf("d%0d end busy", s), 32'(o_busy[s]), 32'd0);
    chk($sformatf("d%0d end vec", s), 32'(o_vec[s]), 32'(vend));
    chk($sformatf("d%0d end mis", s), 32'(o_mis[s]), 32'(mm[vend]));
    chk($sformatf("d%0d end err", s), 32'(o_err[s]), 32'(ecnt));
    if (STOP && found) chk($sformatf("d%0d fail_vec", s), 32'(o_fv[s]), 32'(vend));
    @(negedge clk);
    chk($sformatf("d%0d post done", s), 32'(o_done[s]), 32'd0);
    chk($sformatf("d%0d post vec", s), 32'(o_vec[s]), 32'(vend));
    chk($sformatf("d%0d post err", s), 32'(o_err[s]), 32'(ecnt));
  endtask

  initial begin
    st       = 2'b00;
    cfg_r[0] = '0;
    cfg_r[1] = '0;
    exp_r[0] = '0;
    exp_r[1] = '0;
    rst      = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst d%0d vec", s), 32'(o_vec[s]), 32'd0);
      chk($sformatf("rst d%0d mis", s), 32'(o_mis[s]), 32'd0);
      chk($sformatf("rst d%0d err", s), 32'(o_err[s]), 32'd0);
      chk($sformatf("rst d%0d busy", s), 32'(o_busy[s]), 32'd0);
      chk($sformatf("rst d%0d done", s), 32'(o_done[s]), 32'd0);
      chk($sformatf("rst d%0d fv", s), 32'(o_fv[s]), 32'd0);
    end
    rst = 1'b0;

    run_sweep(0, 16'hC8AF, 16'h48A5, 1'b0);
    run_sweep(1, 16'hC8AF, 16'h48A5, 1'b0);
    run_sweep(0, 16'hC8AF, 16'h48A4, 1'b0);
    run_sweep(0, 16'h5555, 16'h0000, 1'b0);
    run_sweep(1, 16'h5555, 16'h0000, 1'b0);
    run_sweep(0, 16'hC8AF, 16'h48A5, 1'b1);
    run_sweep(0, 16'h5555, 16'h0000, 1'b1);
    run_sweep(1, 16'hC8AF, 16'h48A5, 1'b1);

    for (int k = 0; k < 12; k++) begin
      run_sweep(k % 2, 16'($urandom), 16'($urandom), bit'($urandom_range(0, 1)));
    end

    // Reset in the middle of a sweep
    @(negedge clk);
    cfg_r[0] = 16'hC8AF;
    exp_r[0] = 16'h0000;
    st[0]    = 1'b1;
    @(negedge clk);
    st[0]    = 1'b0;
    repeat (5) @(negedge clk);
    if (!STOP) chk("mid vec", 32'(o_vec[0]), 32'd5);
    chk("mid busy", 32'(o_busy[0]), STOP ? 32'd0 : 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst vec", 32'(o_vec[0]), 32'd0);
    chk("mrst err", 32'(o_err[0]), 32'd0);
    chk("mrst mis", 32'(o_mis[0]), 32'd0);
    chk("mrst busy", 32'(o_busy[0]), 32'd0);
    chk("mrst done", 32'(o_done[0]), 32'd0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("idle c%0d done", c), 32'(o_done[0]), 32'd0);
      chk($sformatf("idle c%0d busy", c), 32'(o_busy[0]), 32'd0);
    end
    run_sweep(0, 16'hC8AF, 16'h48A5, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
